// File: rtl/fetch_ibuff_pkg.sv
// Frontend shared definitions: line geometry defaults and the
// instruction-buffer entry record.
package fetch_ibuff_pkg;

  localparam int XLEN_D    = 32;
  localparam int CL_SIZE_D = 128;
  localparam int W_D       = CL_SIZE_D / 32;
  localparam int OFF_W_D   = $clog2(W_D);
  localparam int OB_D      = $clog2(CL_SIZE_D / 8);

  typedef struct packed {
    logic [CL_SIZE_D-1:0] line;
    logic [XLEN_D-1:0]    base;
    logic [OFF_W_D-1:0]   idx;
    logic                 exc;
  } entry_t;

endpackage

// File: rtl/fetch_ibuff_ram.sv
// Line storage for the fetch buffer: two write ports for the
// even/odd lanes, one asynchronous read port for the head.
module fetch_ibuff_ram #(
  parameter int DW    = 160,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          we_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= data_a;
    if (we_b) mem[addr_b] <= data_b;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_ibuff.sv
// Fetch instruction buffer: queues whole cache lines from the
// even/odd fetch lanes and hands out one 32-bit word per handshake.
module fetch_ibuff
  import fetch_ibuff_pkg::*;
#(
  parameter int XLEN    = XLEN_D,
  parameter int CL_SIZE = CL_SIZE_D,
  parameter int DEPTH   = 4,
  parameter int PW      = $clog2(DEPTH),
  parameter int OW      = PW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [1:0]         in_valid,
  input  logic [CL_SIZE-1:0] in_cl_even,
  input  logic [CL_SIZE-1:0] in_cl_odd,
  input  logic [XLEN-1:0]    in_addr_even,
  input  logic [XLEN-1:0]    in_addr_odd,
  input  logic               in_exc_even,
  input  logic               in_exc_odd,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic               out_exc,
  output logic [OW-1:0]      occupancy
);

  localparam int W     = CL_SIZE / 32;
  localparam int OFF_W = $clog2(W);
  localparam int OB    = $clog2(CL_SIZE / 8);
  localparam int DW    = CL_SIZE + XLEN;

  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    tail1;
  logic [OW-1:0]    occ;
  logic [OFF_W-1:0] idx [DEPTH];
  logic [DEPTH-1:0] exc;

  logic             enq;
  logic             both;
  logic [OW-1:0]    n_enq;
  logic [XLEN-1:0]  addr_a;
  logic [CL_SIZE-1:0] cl_a;
  logic             exc_a;
  logic [DW-1:0]    rdata;
  logic [CL_SIZE-1:0] h_line;
  logic [XLEN-1:0]  h_addr;
  logic [OFF_W-1:0] h_idx;
  logic             h_exc;
  logic             fire;
  logic             pop;

  assign occupancy = occ;
  assign in_ready  = occ <= OW'(DEPTH - 2);
  assign enq       = in_ready & (|in_valid);
  assign both      = &in_valid;
  assign tail1     = tail + PW'(1);

  // A lone odd line takes the tail slot through port a.
  assign addr_a = in_valid[0] ? in_addr_even : in_addr_odd;
  assign cl_a   = in_valid[0] ? in_cl_even : in_cl_odd;
  assign exc_a  = in_valid[0] ? in_exc_even : in_exc_odd;

  always_comb begin
    n_enq = '0;
    if (enq) n_enq = both ? OW'(2) : OW'(1);
  end

  fetch_ibuff_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk    (clk),
    .we_a   (enq),
    .addr_a (tail),
    .data_a ({cl_a, addr_a}),
    .we_b   (enq & both),
    .addr_b (tail1),
    .data_b ({in_cl_odd, in_addr_odd}),
    .raddr  (head),
    .rdata  (rdata)
  );

  assign h_line = rdata[DW-1:XLEN];
  assign h_addr = rdata[XLEN-1:0];
  assign h_idx  = idx[head];
  assign h_exc  = exc[head];

  assign out_valid = occ != '0;
  assign out_exc   = h_exc;
  assign out_instr = h_exc ? 32'h0 : h_line[32*int'(h_idx) +: 32];
  assign out_pc    = h_exc ? {h_addr[XLEN-1:2], 2'b00}
                           : {h_addr[XLEN-1:OB], h_idx, 2'b00};

  assign fire = out_valid & out_ready;
  assign pop  = fire & (h_exc | (h_idx == OFF_W'(W - 1)));

  // Enqueue needs two free slots, so tail writes never touch the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
      exc  <= '0;
      for (int i = 0; i < DEPTH; i++) idx[i] <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (enq) begin
        tail      <= both ? tail + PW'(2) : tail1;
        idx[tail] <= addr_a[OB-1:2];
        exc[tail] <= exc_a;
        if (both) begin
          idx[tail1] <= in_addr_odd[OB-1:2];
          exc[tail1] <= in_exc_odd;
        end
      end
      if (fire) begin
        if (pop) head <= head + PW'(1);
        else     idx[head] <= h_idx + OFF_W'(1);
      end
      occ <= occ + n_enq - (pop ? OW'(1) : OW'(0));
    end
  end

endmodule
